// File: rtl/serial_adder_ctl.sv
// Bit-serial adder controller: shifts operands LSB-first through an external
// XNOR cell and accumulates the sum one bit per clock.
module serial_adder_ctl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             bit_a,
  output logic             bit_b,
  input  logic             xnor_y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_r;
  logic             p;
  logic             in_shift;

  // The propagate term comes only from the external cell, never from a^b here.
  assign p        = ~xnor_y;
  assign in_shift = (state == SHIFT);

  assign bit_a = in_shift & sh_a[0];
  assign bit_b = in_shift & sh_b[0];
  assign busy  = in_shift;
  assign done  = (state == DONE);
  assign sum   = sum_r;
  assign cout  = cout_r;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      sum_r  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
            sum_r <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sum_r <= {p ^ carry, sum_r[WIDTH-1:1]};
          carry <= (sh_a[0] & sh_b[0]) | (carry & p);
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            cout_r <= (sh_a[0] & sh_b[0]) | (carry & p);
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctl.sv
// Directed bench for serial_adder_ctl with a behavioural XNOR cell; WIDTH=8.
module tb_serial_adder_ctl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             bit_a;
  logic             bit_b;
  logic             xnor_y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[7];

  serial_adder_ctl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .bit_a  (bit_a),
    .bit_b  (bit_b),
    .xnor_y (xnor_y),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout)
  );

  assign xnor_y = ~(bit_a ^ bit_b);

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle k+1 (k = accept edge).
  task automatic accept(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walks cycles k+1..k+8 checking busy, then checks the done cycle.
  task automatic finish(input logic [7:0] es, input logic eco, input int glitch);
    for (int i = 1; i <= WIDTH; i++) begin
      check("busy_in_shift", {30'd0, busy, done}, 32'h2);
      if (i == glitch) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_cycle", {30'd0, busy, done}, 32'h1);
    check("sum", sum, es);
    check("cout", cout, eco);
    check("bits_in_done", {bit_a, bit_b}, 2'b00);
  endtask

  // After the done cycle: back to IDLE with the result held.
  task automatic after_done(input logic [7:0] es, input logic eco);
    @(negedge clk);
    check("idle_after_done", {30'd0, busy, done}, 32'h0);
    check("sum_held", {cout, sum}, {eco, es});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};

    reset = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, cout, bit_a, bit_b, sum}, 13'd0);

    // First edge with reset low must accept the start.
    reset = 1'b0;
    accept(8'h5A, 8'h3C, 1'b0);
    finish(8'h96, 1'b0, 0);
    after_done(8'h96, 1'b0);

    foreach (vecs[i]) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].cin);
      finish(vecs[i].s, vecs[i].co, 0);
      after_done(vecs[i].s, vecs[i].co);
    end

    // Start pulsed mid-operation must be ignored.
    accept(8'h12, 8'h34, 1'b0);
    finish(8'h46, 1'b0, 3);
    after_done(8'h46, 1'b0);

    // Reset during SHIFT abandons the add without a done pulse.
    d0 = done_cnt;
    accept(8'h80, 8'h80, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_abort_state", {busy, done, cout, bit_a, bit_b, sum}, 13'd0);
    repeat (WIDTH) @(negedge clk);
    check("reset_abort_no_done", done_cnt, d0);
    accept(8'h01, 8'h02, 1'b0);
    finish(8'h03, 1'b0, 0);
    after_done(8'h03, 1'b0);

    // Start during DONE is ignored; start on the following cycle is accepted.
    accept(8'h0F, 8'h01, 1'b0);
    finish(8'h10, 1'b0, 0);
    start = 1'b1; a = 8'hC0; b = 8'h50; cin = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", {30'd0, busy, done}, 32'h0);
    check("sum_after_done_start", {cout, sum}, {1'b0, 8'h10});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    finish(8'h11, 1'b1, 0);
    after_done(8'h11, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
